afe_config_sequencer: RTL

Power-up configuration engine for the AFE. On a start pulse it walks the AFE command ROM from address 0 and decodes each 24-bit entry. Each valid 20-bit command is serialised to the AFE over a 3-wire SPI write. It stops at the terminator entry and reports done, or reports an error. It sits between the AFE command ROM and the AFE SPI pins, and is the only driver of that SPI bus.

---
 rtl/afe_cfg_pkg.sv | 28 ++
 rtl/afe_spi_shifter.sv | 125 ++++++++++++
 rtl/afe_config_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/afe_cfg_pkg.sv
// Shared opcodes, widths and state encodings for the AFE power-up sequencer.
package afe_cfg_pkg;

  localparam logic [3:0] OP_STOP = 4'h0;
  localparam logic [3:0] OP_SEND = 4'h1;

  localparam int AFE_FRAME_BITS = 20;
  localparam int ROM_ADDR_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } afe_seq_state_t;

  // Serialiser phases: CS setup, SCLK high half, SCLK low half, trailing hold.
  typedef enum logic [1:0] {
    PH_SETUP,
    PH_HIGH,
    PH_LOW,
    PH_HOLD
  } afe_spi_phase_t;

endpackage

// File: rtl/afe_spi_shifter.sv
// 3-wire SPI write serialiser: SCLK divider, 20-bit shift register, SEN timing.
// Optional AFE_SDOUT_CAPTURE_EN: samples spi_sdout on SCLK rising edges and
// loads the last 8 samples into readback when SEN rises.
module afe_spi_shifter
  import afe_cfg_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [AFE_FRAME_BITS-1:0] payload,
  output logic                      frame_done,
  output logic                      spi_sclk,
  output logic                      spi_sen,
  output logic                      spi_sdata
`ifdef AFE_SDOUT_CAPTURE_EN
  ,
  input  logic                      spi_sdout,
  output logic [7:0]                readback
`endif
);

  localparam int FB = AFE_FRAME_BITS;
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  // The final SCLK low half plus the trailing hold keep SEN low 2*CLK_DIV
  // cycles after the last falling edge, giving CS_SETUP + 41*CLK_DIV in total.
  localparam logic [15:0] HOLD_LAST  = 16'(2 * CLK_DIV - 1);
  localparam logic [4:0]  LAST_BIT   = 5'(FB - 1);

  logic           active;
  afe_spi_phase_t phase;
  logic [15:0]    cnt;
  logic [4:0]     bit_idx;
  logic [FB-1:0]  sr;
  logic           sclk_rise;

  // Last hold cycle: SEN rises at the edge closing this cycle.
  assign frame_done = active && (phase == PH_HOLD) && (cnt == HOLD_LAST);
  // Cycle whose closing edge drives SCLK 0->1.
  assign sclk_rise  = active && (((phase == PH_SETUP) && (cnt == SETUP_LAST)) ||
                                 ((phase == PH_LOW)   && (cnt == DIV_LAST)));

  // Frame timing and shift datapath; all pins come straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active    <= 1'b0;
      phase     <= PH_SETUP;
      cnt       <= '0;
      bit_idx   <= '0;
      sr        <= '0;
      spi_sclk  <= 1'b0;
      spi_sen   <= 1'b1;
      spi_sdata <= 1'b0;
    end else if (!active) begin
      if (load) begin
        active    <= 1'b1;
        phase     <= PH_SETUP;
        cnt       <= '0;
        bit_idx   <= '0;
        spi_sen   <= 1'b0;
        spi_sdata <= payload[FB-1];
        sr        <= {payload[FB-2:0], 1'b0};
      end
    end else begin
      unique case (phase)
        PH_SETUP: begin
          if (cnt == SETUP_LAST) begin
            spi_sclk <= 1'b1;
            phase    <= PH_HIGH;
            cnt      <= '0;
          end else cnt <= cnt + 16'd1;
        end
        PH_HIGH: begin
          if (cnt == DIV_LAST) begin
            spi_sclk <= 1'b0;
            cnt      <= '0;
            if (bit_idx == LAST_BIT) begin
              phase     <= PH_HOLD;
              spi_sdata <= 1'b0;
            end else begin
              phase     <= PH_LOW;
              bit_idx   <= bit_idx + 5'd1;
              spi_sdata <= sr[FB-1];
              sr        <= {sr[FB-2:0], 1'b0};
            end
          end else cnt <= cnt + 16'd1;
        end
        PH_LOW: begin
          if (cnt == DIV_LAST) begin
            spi_sclk <= 1'b1;
            phase    <= PH_HIGH;
            cnt      <= '0;
          end else cnt <= cnt + 16'd1;
        end
        PH_HOLD: begin
          if (cnt == HOLD_LAST) begin
            spi_sen <= 1'b1;
            active  <= 1'b0;
            cnt     <= '0;
          end else cnt <= cnt + 16'd1;
        end
        default: phase <= PH_SETUP;
      endcase
    end
  end

`ifdef AFE_SDOUT_CAPTURE_EN
  logic [7:0] cap;

  // Sample SDOUT with each SCLK rise; publish the trailing byte as SEN rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap      <= '0;
      readback <= '0;
    end else begin
      if (sclk_rise)  cap      <= {cap[6:0], spi_sdout};
      if (frame_done) readback <= cap;
    end
  end
`endif

endmodule

// File: rtl/afe_config_sequencer.sv
// AFE power-up configuration engine: walks the command ROM from address 0,
// sends SEND payloads over 3-wire SPI, stops on STOP or a reserved opcode.
// Optional AFE_SDOUT_CAPTURE_EN adds spi_sdout / readback.
module afe_config_sequencer
  import afe_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int GAP_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic [ROM_ADDR_BITS-1:0] rom_address,
  input  logic [23:0]              rom_command,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [7:0]               cmd_count,
  output logic                     spi_sclk,
  output logic                     spi_sen,
  output logic                     spi_sdata
`ifdef AFE_SDOUT_CAPTURE_EN
  ,
  input  logic                     spi_sdout,
  output logic [7:0]               readback
`endif
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [ROM_ADDR_BITS-1:0] ADDR_MAX = '1;

  afe_seq_state_t state, next_state;
  logic           load;
  logic           frame_done;
  logic [15:0]    gap_cnt;
  logic [3:0]     opcode;

  assign opcode = rom_command[23:20];

  afe_spi_shifter #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP)
  ) u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .payload    (rom_command[AFE_FRAME_BITS-1:0]),
    .frame_done (frame_done),
    .spi_sclk   (spi_sclk),
    .spi_sen    (spi_sen),
    .spi_sdata  (spi_sdata)
`ifdef AFE_SDOUT_CAPTURE_EN
    ,
    .spi_sdout  (spi_sdout),
    .readback   (readback)
`endif
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state decode; load fires on an accepted SEND entry.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) next_state = ST_FETCH;
      ST_FETCH: next_state = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OP_STOP) next_state = ST_DONE;
        else if (opcode == OP_SEND) begin
          next_state = ST_SHIFT;
          load       = 1'b1;
        end else next_state = ST_ERROR;
      end
      ST_SHIFT: if (frame_done) next_state = ST_GAP;
      ST_GAP: begin
        if (gap_cnt == GAP_LAST)
          next_state = (rom_address == ADDR_MAX) ? ST_ERROR : ST_FETCH;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Addressing, status flags, frame counter and inter-frame gap timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cmd_count   <= '0;
      gap_cnt     <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            rom_address <= '0;
            cmd_count   <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ST_DECODE: begin
          gap_cnt <= '0;
          if (opcode == OP_STOP) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else if (opcode != OP_SEND) begin
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          gap_cnt <= '0;
          if (frame_done && (cmd_count != 8'hFF)) cmd_count <= cmd_count + 8'd1;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (rom_address == ADDR_MAX) begin
              error <= 1'b1;
              busy  <= 1'b0;
            end else rom_address <= rom_address + 1'b1;
          end else gap_cnt <= gap_cnt + 16'd1;
        end
        default: gap_cnt <= '0;
      endcase
    end
  end

endmodule
